// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory arbiter slice.
package lc3_mem_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rr_pick_t;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output rr_pick_t   pick_c
);

  always_comb begin
    pick_c.valid = |req;
    pick_c.id    = ID_CPU;
    if (req[ID_DMA] && (!req[ID_CPU] || (last_gnt == ID_CPU))) begin
      pick_c.id = ID_DMA;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the LC-3 memory port between the CPU and the DMA/loader port.
// Optional wait-state timeout enabled by defining LC3_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  input  logic          DMA_REQ,
  input  logic          DMA_WE,
  input  logic [AW-1:0] DMA_ADDR,
  input  logic [DW-1:0] DMA_WDATA,
  output logic          DMA_ACK,
  output logic [DW-1:0] DMA_RDATA,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_READY,
  output logic          BUSY,
  output logic          GNT_ID,
  output logic          ERR
);

  if (MAX_WAIT == 0) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          gnt_id_q, gnt_id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          xfer_end;
  rr_pick_t      pick;

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic          err_q, err_d;
`endif

  lc3_rr_arb2 u_rr_arb2 (
    .req      ({DMA_REQ, CPU_REQ}),
    .last_gnt (last_gnt_q),
    .pick_c   (pick)
  );

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    busy_d      = busy_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    xfer_end    = 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    wait_inc    = wait_cnt_q + CW'(1);
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          state_d    = ACCESS;
          last_gnt_d = pick.id;
          gnt_id_d   = pick.id;
          busy_d     = 1'b1;
          mem_en_d   = 1'b1;
          if (pick.id == ID_DMA) begin
            mem_we_d = DMA_WE;
            addr_d   = DMA_ADDR;
            wdata_d  = DMA_WDATA;
          end else begin
            mem_we_d = CPU_WE;
            addr_d   = CPU_ADDR;
            wdata_d  = CPU_WDATA;
          end
`ifdef LC3_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      ACCESS: begin
        if (MEM_READY) begin
          xfer_end = 1'b1;
          if (!mem_we_q) begin
            if (gnt_id_q == ID_DMA) dma_rdata_d = MEM_RDATA;
            else                    cpu_rdata_d = MEM_RDATA;
          end
`ifdef LC3_ARB_TIMEOUT_EN
        end else if (wait_inc == CW'(MAX_WAIT)) begin
          // Give up: complete with ERR and a zeroed read result.
          xfer_end = 1'b1;
          err_d    = 1'b1;
          if (!mem_we_q) begin
            if (gnt_id_q == ID_DMA) dma_rdata_d = '0;
            else                    cpu_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_inc;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (xfer_end) begin
      state_d   = DONE;
      mem_en_d  = 1'b0;
      mem_we_d  = 1'b0;
      cpu_ack_d = (gnt_id_q == ID_CPU);
      dma_ack_d = (gnt_id_q == ID_DMA);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      last_gnt_q  <= ID_DMA;
      gnt_id_q    <= ID_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

`ifdef LC3_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign CPU_ACK   = cpu_ack_q;
  assign DMA_ACK   = dma_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign DMA_RDATA = dma_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = busy_q;
  assign GNT_ID    = gnt_id_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized
// request/wait-state traffic against a transaction-level model.
module tb_lc3_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CPU_REQ, CPU_WE, DMA_REQ, DMA_WE;
  logic [15:0] CPU_ADDR, CPU_WDATA, DMA_ADDR, DMA_WDATA;
  logic        CPU_ACK, DMA_ACK;
  logic [15:0] CPU_RDATA, DMA_RDATA;
  logic        MEM_EN, MEM_WE, MEM_READY;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        BUSY, GNT_ID, ERR;

  int checks = 0;
  int errors = 0;

  // Requester intent and expected read results, per requester (0=CPU, 1=DMA).
  bit          pend      [2];
  logic        rq_we     [2];
  logic [15:0] rq_addr   [2];
  logic [15:0] rq_wdata  [2];
  logic [15:0] exp_rdata [2];
  logic        model_last;

  lc3_mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA),
    .DMA_ACK(DMA_ACK), .DMA_RDATA(DMA_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
    .BUSY(BUSY), .GNT_ID(GNT_ID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input int id);
    if (id == 0) begin
      CPU_REQ = pend[0]; CPU_WE = rq_we[0]; CPU_ADDR = rq_addr[0]; CPU_WDATA = rq_wdata[0];
    end else begin
      DMA_REQ = pend[1]; DMA_WE = rq_we[1]; DMA_ADDR = rq_addr[1]; DMA_WDATA = rq_wdata[1];
    end
  endtask

  task automatic new_req(input int id, input logic we, input logic [15:0] a, input logic [15:0] d);
    pend[id] = 1'b1; rq_we[id] = we; rq_addr[id] = a; rq_wdata[id] = d;
    drive_req(id);
  endtask

  task automatic check_done_common(input int w);
    check("done_cpu_ack", 32'(CPU_ACK), 32'(w == 0));
    check("done_dma_ack", 32'(DMA_ACK), 32'(w == 1));
    check("done_cpu_rdata", 32'(CPU_RDATA), 32'(exp_rdata[0]));
    check("done_dma_rdata", 32'(DMA_RDATA), 32'(exp_rdata[1]));
    check("done_mem_en", 32'(MEM_EN), 32'd0);
    check("done_busy", 32'(BUSY), 32'd1);
    check("done_gnt", 32'(GNT_ID), 32'(w));
  endtask

  // One complete transaction, entered and left in an IDLE cycle just after the clock edge.
  task automatic txn(input int waits, input bit perturb, input logic [15:0] rd);
    int w, o;
    logic cw;
    logic [15:0] ca, cd;
    if (pend[0] && pend[1]) w = model_last ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    o = 1 - w;
    model_last = w[0];
    cw = rq_we[w]; ca = rq_addr[w]; cd = rq_wdata[w];
    drive_req(0); drive_req(1);
    @(negedge CLK);
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_mem_en", 32'(MEM_EN), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge CLK); #1;
      MEM_READY = (i == waits);
      MEM_RDATA = (i == waits) ? rd : 16'($urandom);
      if (!pend[o] && $urandom_range(0, 3) == 0)
        new_req(o, 1'($urandom), 16'($urandom), 16'($urandom));
      if (perturb && i == 0) begin
        if (w == 0) begin CPU_ADDR = ~ca; CPU_WDATA = ~cd; CPU_WE = ~cw; CPU_REQ = 1'b0; end
        else        begin DMA_ADDR = ~ca; DMA_WDATA = ~cd; DMA_WE = ~cw; DMA_REQ = 1'b0; end
      end
      @(negedge CLK);
      check("acc_mem_en", 32'(MEM_EN), 32'd1);
      check("acc_mem_we", 32'(MEM_WE), 32'(cw));
      check("acc_mem_addr", 32'(MEM_ADDR), 32'(ca));
      check("acc_mem_wdata", 32'(MEM_WDATA), 32'(cd));
      check("acc_busy", 32'(BUSY), 32'd1);
      check("acc_gnt", 32'(GNT_ID), 32'(w));
      check("acc_no_ack", 32'({CPU_ACK, DMA_ACK}), 32'd0);
    end
    @(posedge CLK); #1;
    MEM_READY = 1'b0;
    MEM_RDATA = 16'($urandom);
    if (!cw) exp_rdata[w] = rd;
    @(negedge CLK);
    check_done_common(w);
    check("done_err", 32'(ERR), 32'd0);
    pend[w] = 1'b0;
    @(posedge CLK); #1;
    drive_req(w);
  endtask

  initial begin
    int ack_seen;
    RESET_N = 1'b0;
    MEM_READY = 1'b0; MEM_RDATA = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0; exp_rdata[i] = '0;
      drive_req(i);
    end
    model_last = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_outputs", 32'({CPU_ACK, DMA_ACK, MEM_EN, MEM_WE, BUSY, GNT_ID, ERR}), 32'd0);
    check("rst_mem_bus", 32'({MEM_ADDR, MEM_WDATA}), 32'd0);
    check("rst_rdata", 32'({CPU_RDATA, DMA_RDATA}), 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Tie from reset goes to CPU, then alternation CPU, DMA, CPU.
    new_req(0, 1'b0, 16'h0100, 16'h0);
    new_req(1, 1'b0, 16'h0200, 16'h0);
    txn(0, 1'b0, 16'hAAAA);
    new_req(0, 1'b1, 16'h0101, 16'h5A5A);
    txn(0, 1'b0, 16'hBBBB);
    txn(1, 1'b0, 16'hCCCC);

    // Plain CPU read, zero-wait memory.
    new_req(0, 1'b0, 16'h3000, 16'h0);
    txn(0, 1'b0, 16'h1234);

    // DMA write with three wait states; DMA_RDATA must not move.
    new_req(1, 1'b1, 16'h4000, 16'hBEEF);
    txn(3, 1'b0, 16'hDEAD);

    // Owner changes address and drops REQ mid-access.
    new_req(0, 1'b1, 16'h3001, 16'h0F0F);
    txn(2, 1'b1, 16'h0);

    // Memory never ready.
    new_req(0, 1'b0, 16'h3002, 16'h0);
    model_last = 1'b0;
    @(posedge CLK); #1;
`ifdef LC3_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      check("to_wait_ack", 32'(CPU_ACK), 32'd0);
      check("to_wait_en", 32'(MEM_EN), 32'd1);
      @(posedge CLK); #1;
    end
    exp_rdata[0] = 16'h0;
    @(negedge CLK);
    check_done_common(0);
    check("to_err", 32'(ERR), 32'd1);
`else
    ack_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (CPU_ACK || DMA_ACK || ERR) ack_seen++;
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("no_to_ack", 32'(ack_seen), 32'd0);
    check("no_to_still_en", 32'(MEM_EN), 32'd1);
    MEM_READY = 1'b1; MEM_RDATA = 16'h7777;
    @(posedge CLK); #1;
    MEM_READY = 1'b0;
    exp_rdata[0] = 16'h7777;
    @(negedge CLK);
    check_done_common(0);
    check("no_to_err", 32'(ERR), 32'd0);
`endif
    pend[0] = 1'b0;
    @(posedge CLK); #1;
    drive_req(0);

    // Reset in the middle of an access: everything drops at once, no ACK.
    new_req(0, 1'b0, 16'h5555, 16'h0);
    @(posedge CLK); #1;
    MEM_READY = 1'b0;
    @(negedge CLK);
    check("rst_pre_en", 32'(MEM_EN), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("rst_mid_en", 32'(MEM_EN), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_ack", 32'({CPU_ACK, DMA_ACK}), 32'd0);
    check("rst_mid_rdata", 32'({CPU_RDATA, DMA_RDATA}), 32'd0);
    pend[0] = 1'b0; drive_req(0);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    model_last = 1'b1;
    @(posedge CLK); #1;
    check("rst_hold_ack", 32'({CPU_ACK, DMA_ACK, GNT_ID}), 32'd0);
    RESET_N = 1'b1;
    new_req(0, 1'b0, 16'h0010, 16'h0);
    new_req(1, 1'b0, 16'h0020, 16'h0);
    txn(0, 1'b0, 16'h1111);
    txn(0, 1'b0, 16'h2222);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      for (int id = 0; id < 2; id++)
        if (!pend[id] && $urandom_range(0, 1) == 1)
          new_req(id, 1'($urandom), 16'($urandom), 16'($urandom));
      if (!pend[0] && !pend[1]) begin
        @(negedge CLK);
        check("rnd_idle_busy", 32'(BUSY), 32'd0);
        check("rnd_idle_en", 32'({MEM_EN, CPU_ACK, DMA_ACK}), 32'd0);
        @(posedge CLK); #1;
      end else begin
        txn($urandom_range(0, 4), $urandom_range(0, 3) == 0, 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Shares the single LC-3 memory port between two requesters: the CPU datapath (MAR/MDR path sequenced by the control FSM) and a DMA/loader port used for program load and console I/O buffers. Round-robin grant, registered address/data capture, wait-state support via MEM_READY, and a one-cycle ACK per transaction. Sits between the CPU memory interface and the memory/MMIO block.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_WAIT, 15, wait-state limit in cycles (used only with LC3_ARB_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
CPU_REQ  in  1  CPU access request, held until CPU_ACK
CPU_WE  in  1  1=write, 0=read
CPU_ADDR  in  AW  CPU address (MAR)
CPU_WDATA  in  DW  CPU write data (MDR)
CPU_ACK  out  1  one-cycle completion pulse
CPU_RDATA  out  DW  read data, valid with CPU_ACK, held until next CPU read ACK
DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_ACK, DMA_RDATA: same as CPU_* for the DMA port
MEM_EN  out  1  memory access strobe
MEM_WE  out  1  memory write enable
MEM_ADDR  out  AW  memory address
MEM_WDATA  out  DW  memory write data
MEM_RDATA  in  DW  memory read data, valid when MEM_READY=1
MEM_READY  in  1  access complete this cycle
BUSY  out  1  1 in any state except IDLE
GNT_ID  out  1  owner of current/last transaction: 0=CPU, 1=DMA
ERR  out  1  one-cycle timeout pulse (tied 0 without macro)

Behaviour:
- States: IDLE, ACCESS, DONE. Reset: state=IDLE; all outputs 0 (RDATA buses 0); LAST_GNT=1, so the CPU wins the first tie.
- IDLE: REQ sampled only here. Only one REQ set -> grant it. Both set -> grant !LAST_GNT. None set -> stay. On grant, register ADDR/WE/WDATA/ID, update LAST_GNT, go to ACCESS.
- ACCESS: MEM_EN=1, MEM_WE/ADDR/WDATA driven from the captured registers and held stable. On MEM_READY=1, capture MEM_RDATA into the owner's RDATA (reads only) and go to DONE. Otherwise stay.
- DONE: owner's ACK=1 for exactly one cycle; MEM_EN=0; then go to IDLE.
- Latency with a zero-wait memory (MEM_READY=1 in the first ACCESS cycle): REQ seen in cycle T, ACCESS at T+1, ACK at T+2. Minimum turnaround is 3 cycles per transaction.
- Requesters deassert REQ on the edge that samples ACK=1. REQ still high in the following IDLE cycle is a new request.
- REQ dropped during ACCESS: the access still completes and ACK is still pulsed. No abort.
- Input changes after grant have no effect on the current transaction.
- A write never updates RDATA. The non-owner's ACK and RDATA are untouched.
- RESET_N low at any time, including mid-ACCESS: immediate return to the reset values (MEM_EN drops asynchronously). The transaction is lost and no ACK is issued.
- MEM_RDATA is ignored whenever MEM_READY=0.

Optional Feature:
LC3_ARB_TIMEOUT_EN
- Defined: a wait counter clears on entry to ACCESS and increments each cycle with MEM_READY=0. When it reaches MAX_WAIT with MEM_READY still 0, go to DONE: owner ACK=1, ERR=1 for that same cycle, and owner RDATA=0 on a read. The counter width is clog2(MAX_WAIT+1).
- Undefined: no counter; ACCESS waits indefinitely; ERR tied to 0.

Decomposition:
- Package lc3_mem_pkg: state encoding (IDLE=0, ACCESS=1, DONE=2), requester IDs (ID_CPU=0, ID_DMA=1), default AW/DW.
- Sub-module lc3_rr_arb2: combinational two-way round-robin pick from (REQ pair, LAST_GNT) -> (valid, id). LAST_GNT register stays in the parent.

Test Plan:
- CPU read only, addr 16'h3000, MEM_READY=1 with MEM_RDATA=16'h1234 -> CPU_ACK at T+2, CPU_RDATA=16'h1234, DMA_ACK never set, GNT_ID=0.
- CPU and DMA both request from reset -> CPU granted first, DMA next (IDLE between them); CPU re-requests -> order alternates CPU, DMA, CPU.
- DMA write addr 16'h4000 data 16'hBEEF, MEM_READY delayed 3 cycles -> MEM_EN/ADDR/WDATA/WE stable for 4 cycles, DMA_ACK 1 cycle after READY, DMA_RDATA unchanged.
- RESET_N pulsed low mid-ACCESS -> MEM_EN=0 immediately, BUSY=0, no ACK; after release, a CPU tie wins.
- CPU_ADDR changed and CPU_REQ dropped during ACCESS -> MEM_ADDR keeps the captured value, CPU_ACK still pulses.
- With LC3_ARB_TIMEOUT_EN, MAX_WAIT=15, MEM_READY held 0 -> ACK and ERR together after 15 wait cycles, CPU_RDATA=0; without the macro the bench sees no ACK after 100 cycles.
